// File: rtl/vga_pkg.sv
// Shared VGA constants, PS/2 scan codes and the pixel colour type for the 640x480 output path.
package vga_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;

  typedef logic [23:0] bgr_t;

  // Saturating move of a box coordinate: never wraps below 0 or above limit.
  function automatic logic [9:0] step_clamp(input logic [9:0] pos, input logic down,
                                            input logic [9:0] step, input logic [9:0] limit);
    if (down) return (pos < step) ? 10'd0 : pos - step;
    return (({1'b0, pos} + {1'b0, step}) > {1'b0, limit}) ? limit : pos + step;
  endfunction

endpackage

// File: rtl/vga_pixel_source_if.sv
// Frame address to (x, y) coordinate bus between the pixel source and its decoder.
interface vga_pixel_source_if;
  logic [18:0] addr;
  logic [9:0]  addr_x;
  logic [9:0]  addr_y;

  modport master (output addr, input addr_x, input addr_y);
  modport slave  (input addr, output addr_x, output addr_y);
endinterface

// File: rtl/vga_pixel_source_addr_xy_decoder.sv
// Combinational split of the linear frame address into column and row.
module addr_xy_decoder
  import vga_pkg::*;
(
  vga_pixel_source_if.slave bus
);

  assign bus.addr_x = 10'(bus.addr % 19'(H_ACTIVE));
  assign bus.addr_y = 10'(bus.addr / 19'(H_ACTIVE));

endmodule

// File: rtl/vga_pixel_source.sv
// VGA pixel source: frame address, image/palette ROM fetch, box overlay, negedge re-timed outputs.
// Define KEY_MOVE_EN to compile in PS/2 arrow-key movement of the box; otherwise it stays at (320,240).
module vga_pixel_source
  import vga_pkg::*;
#(
  parameter int   BOX_W     = 64,
  parameter int   BOX_H     = 48,
  parameter bgr_t BOX_COLOR = 24'hFFFF00,
  parameter int   MOVE_STEP = 10
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       cHS,
  input  logic       cVS,
  input  logic       cBLANK_n,
  input  logic [7:0] key_in,
  input  logic       key_en,
  output logic       oHS,
  output logic       oVS,
  output logic       oBLANK_n,
  output logic [7:0] b_data,
  output logic [7:0] g_data,
  output logic [7:0] r_data
);

  localparam logic [9:0]  BX_RST    = 10'd320;
  localparam logic [9:0]  BY_RST    = 10'd240;
  localparam logic [9:0]  BX_MAX    = 10'(H_ACTIVE - 1 - BOX_W);
  localparam logic [9:0]  BY_MAX    = 10'(V_ACTIVE - 1 - BOX_H);
  localparam logic [9:0]  STEP      = 10'(MOVE_STEP);
  localparam logic [18:0] ADDR_LAST = 19'(FRAME_PIXELS - 1);

  // Image and palette ROMs; contents are loaded from the hex images by the build flow.
  logic [7:0] idx_rom [FRAME_PIXELS] = '{default: '0};
  bgr_t       pal_rom [256]          = '{default: '0};

  logic [18:0] addr_q, addr_d;
  logic [9:0]  bx_q, bx_d, by_q, by_d;
  logic [7:0]  idx_q;
  bgr_t        pal_q, bgr_q;
  logic        hit_n_q, hit_p_q, box_hit;

  vga_pixel_source_if xy_bus ();
  assign xy_bus.addr = addr_q;

  addr_xy_decoder u_addr_xy_decoder (.bus(xy_bus.slave));

  // NOTE: default first, so no path leaves addr_d unassigned and no latch is inferred.
  always_comb begin
    addr_d = addr_q;
    if (!cHS && !cVS)  addr_d = '0;
    else if (cBLANK_n) addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 19'd1;
  end

`ifdef KEY_MOVE_EN
  logic key_en_q;
  logic key_rise;
  assign key_rise = key_en & ~key_en_q;

  always_comb begin
    bx_d = bx_q;
    by_d = by_q;
    if (key_rise) begin
      case (key_in)
        KEY_UP:    by_d = step_clamp(by_q, 1'b1, STEP, BY_MAX);
        KEY_DOWN:  by_d = step_clamp(by_q, 1'b0, STEP, BY_MAX);
        KEY_LEFT:  bx_d = step_clamp(bx_q, 1'b1, STEP, BX_MAX);
        KEY_RIGHT: bx_d = step_clamp(bx_q, 1'b0, STEP, BX_MAX);
        default:   ;
      endcase
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) key_en_q <= 1'b0;
    else         key_en_q <= key_en;
  end
`else
  logic unused_keys;
  assign unused_keys = ^{key_in, key_en};
  assign bx_d = bx_q;
  assign by_d = by_q;
`endif

  assign box_hit = (xy_bus.addr_x >= bx_q) && ({1'b0, xy_bus.addr_x} <= ({1'b0, bx_q} + 11'(BOX_W)))
                && (xy_bus.addr_y >= by_q) && ({1'b0, xy_bus.addr_y} <= ({1'b0, by_q} + 11'(BOX_H)));

  // NOTE: non-blocking assignments so every flop samples the values from before the edge.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      addr_q  <= '0;
      bx_q    <= BX_RST;
      by_q    <= BY_RST;
      pal_q   <= '0;
      hit_p_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      pal_q   <= pal_rom[idx_q];
      hit_p_q <= hit_n_q;
    end
  end

  // NOTE: the ROM arrays carry no reset; only their read registers do.
  always_ff @(negedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      idx_q    <= '0;
      hit_n_q  <= 1'b0;
      bgr_q    <= '0;
      oHS      <= 1'b1;
      oVS      <= 1'b1;
      oBLANK_n <= 1'b0;
    end else begin
      idx_q    <= idx_rom[addr_q];
      hit_n_q  <= box_hit;
      bgr_q    <= hit_p_q ? BOX_COLOR : pal_q;
      oHS      <= cHS;
      oVS      <= cVS;
      oBLANK_n <= cBLANK_n;
    end
  end

  assign {b_data, g_data, r_data} = bgr_q;

endmodule

// File: tb/tb_vga_pixel_source.sv
// Self-checking bench for vga_pixel_source: frame-level model of address, box and pixel colour.
module tb_vga_pixel_source;
  import vga_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hs = 1'b1, vs = 1'b1, blank = 1'b0;
  logic [7:0] key_in = 8'h00;
  logic       key_en = 1'b0;
  logic       o_hs, o_vs, o_blank;
  logic [7:0] b_d, g_d, r_d;

  always #5 clk = ~clk;

  vga_pixel_source dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .cHS(hs), .cVS(vs), .cBLANK_n(blank),
    .key_in(key_in), .key_en(key_en), .oHS(o_hs), .oVS(o_vs), .oBLANK_n(o_blank),
    .b_data(b_d), .g_data(g_d), .r_data(r_d)
  );

  vga_pixel_source_if dec_bus ();
  addr_xy_decoder u_chk_dec (.bus(dec_bus.slave));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ROM images, frame address and box position as plain integers.
  logic [7:0] idx_m [FRAME_PIXELS];
  bgr_t       pal_m [256];
  int         m_addr, m_bx, m_by, hist;
  bit         m_kprev, run;
  bgr_t       cur, prev;
  logic [18:0] force_val;

  function automatic bgr_t pixel(input int a, input int bx, input int by);
    int x, y;
    x = a % H_ACTIVE;
    y = a / H_ACTIVE;
    if (x >= bx && x <= bx + 64 && y >= by && y <= by + 48) return 24'hFFFF00;
    return pal_m[idx_m[a]];
  endfunction

  always @(posedge clk) if (run) begin : model
    bit h, v, b, ke;
    logic [7:0] kc;
    h = hs; v = vs; b = blank; ke = key_en; kc = key_in;
    if (!h && !v) m_addr = 0;
    else if (b)   m_addr = (m_addr + 1) % FRAME_PIXELS;
`ifdef KEY_MOVE_EN
    if (ke && !m_kprev) begin
      case (kc)
        8'h75: m_by = (m_by >= 10) ? m_by - 10 : 0;
        8'h72: m_by = (m_by + 10 > 431) ? 431 : m_by + 10;
        8'h6B: m_bx = (m_bx >= 10) ? m_bx - 10 : 0;
        8'h74: m_bx = (m_bx + 10 > 575) ? 575 : m_bx + 10;
        default: ;
      endcase
    end
`endif
    m_kprev = ke;
    #1;
    check("addr", 32'(dut.addr_q), 32'(m_addr));
    check("box_x", 32'(dut.bx_q), 32'(m_bx));
    check("box_y", 32'(dut.by_q), 32'(m_by));
    prev = cur;
    cur  = pixel(m_addr, m_bx, m_by);
    if (hist < 2) hist++;
  end

  always @(negedge clk) if (run) begin
    #1;
    if (hist >= 2) check("pixel", 32'({b_d, g_d, r_d}), 32'(prev));
    check("o_hs", 32'(o_hs), 32'(hs));
    check("o_vs", 32'(o_vs), 32'(vs));
    check("o_blank", 32'(o_blank), 32'(blank));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    m_addr = 0; m_bx = 320; m_by = 240; m_kprev = 1'b0; hist = 0; cur = '0; prev = '0;
  endtask

  // Jump the frame address (called 2 time units after a posedge).
  task set_addr(input int a);
    force_val = 19'(a);
    force dut.addr_q = force_val;
    #1;
    release dut.addr_q;
    m_addr = a;
    hist   = 0;
  endtask

  task automatic do_reset();
    run   = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_pixel", 32'({b_d, g_d, r_d}), 32'h0);
    check("rst_hs", 32'(o_hs), 32'h1);
    check("rst_vs", 32'(o_vs), 32'h1);
    check("rst_blank", 32'(o_blank), 32'h0);
    check("rst_addr", 32'(dut.addr_q), 32'h0);
    check("rst_bx", 32'(dut.bx_q), 32'd320);
    check("rst_by", 32'(dut.by_q), 32'd240);
    tick();
    model_reset();
    rst_n = 1'b1;
    run   = 1'b1;
  endtask

  task automatic key_pulse(input logic [7:0] code);
    key_in = code;
    key_en = 1'b1;
    tick();
    key_en = 1'b0;
    tick();
  endtask

  initial begin
    #1;
    for (int i = 0; i < FRAME_PIXELS; i++) idx_m[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) pal_m[i] = 24'($urandom);
    idx_m[0] = 8'h05;
    pal_m[5] = 24'h123456;
    for (int i = 0; i < FRAME_PIXELS; i++) dut.idx_rom[i] = idx_m[i];
    for (int i = 0; i < 256; i++) dut.pal_rom[i] = pal_m[i];

    // Decoder pinned with literals, then against plain div/mod.
    dec_bus.addr = 19'd641;    #1; check("dec641_x", 32'(dec_bus.addr_x), 32'd1);   check("dec641_y", 32'(dec_bus.addr_y), 32'd1);
    dec_bus.addr = 19'd640;    #1; check("dec640_x", 32'(dec_bus.addr_x), 32'd0);   check("dec640_y", 32'(dec_bus.addr_y), 32'd1);
    dec_bus.addr = 19'd307199; #1; check("declast_x", 32'(dec_bus.addr_x), 32'd639); check("declast_y", 32'(dec_bus.addr_y), 32'd479);
    for (int i = 0; i < 200; i++) begin
      int a;
      a = int'($urandom_range(FRAME_PIXELS - 1, 0));
      dec_bus.addr = 19'(a);
      #1;
      check("dec_x", 32'(dec_bus.addr_x), 32'(a % 640));
      check("dec_y", 32'(dec_bus.addr_y), 32'(a / 640));
    end

    tick();
    tick();
    blank = 1'b1;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("count", 32'(dut.addr_q), 32'(i));
    end

    // Clear to ADDR 0, hold, and see PAL[IDX[0]] at the output.
    hs = 1'b0; vs = 1'b0; blank = 1'b0;
    tick();
    check("clear0", 32'(dut.addr_q), 32'h0);
    hs = 1'b1; vs = 1'b1;
    repeat (3) tick();
    @(negedge clk); #1;
    check("pix_addr0", 32'({b_d, g_d, r_d}), 32'h123456);
    tick();

    set_addr(260 * 640 + 330);
    repeat (3) tick();
    @(negedge clk); #1;
    check("pix_box", 32'({b_d, g_d, r_d}), 32'hFFFF00);
    tick();

    blank = 1'b1;
    set_addr(5000);
    hs = 1'b0; vs = 1'b0;
    tick();
    check("clear5000", 32'(dut.addr_q), 32'h0);
    hs = 1'b1; vs = 1'b1;

    set_addr(307197);
    tick(); check("wrap_m2", 32'(dut.addr_q), 32'd307198);
    tick(); check("wrap_m1", 32'(dut.addr_q), 32'd307199);
    tick(); check("wrap_0", 32'(dut.addr_q), 32'd0);

    key_pulse(8'h6B);
    key_pulse(8'h75);
    key_pulse(8'h10);
`ifdef KEY_MOVE_EN
    check("key_left", 32'(dut.bx_q), 32'd310);
    check("key_up", 32'(dut.by_q), 32'd230);
`else
    check("fixed_bx", 32'(dut.bx_q), 32'd320);
    check("fixed_by", 32'(dut.by_q), 32'd240);
`endif
    key_in = 8'h72; key_en = 1'b1;
    repeat (3) tick();
    key_en = 1'b0;
    tick();
`ifdef KEY_MOVE_EN
    check("key_held", 32'(dut.by_q), 32'd240);
`else
    check("fixed_by2", 32'(dut.by_q), 32'd240);
`endif
    repeat (40) key_pulse(8'h75);
    repeat (40) key_pulse(8'h74);
`ifdef KEY_MOVE_EN
    check("clamp_top", 32'(dut.by_q), 32'd0);
    check("clamp_right", 32'(dut.bx_q), 32'd575);
`else
    check("fixed_bx3", 32'(dut.bx_q), 32'd320);
    check("fixed_by3", 32'(dut.by_q), 32'd240);
`endif

    // Random traffic with periodic address jumps around the box edges.
    for (int c = 0; c < 20000; c++) begin
      logic [7:0] codes [5];
      codes[0] = 8'h75; codes[1] = 8'h72; codes[2] = 8'h6B; codes[3] = 8'h74; codes[4] = 8'($urandom);
      blank = ($urandom_range(7, 0) != 0);
      if ($urandom_range(499, 0) == 0) begin hs = 1'b0; vs = 1'b0; end
      else begin hs = ($urandom_range(19, 0) != 0); vs = 1'b1; end
      if ($urandom_range(24, 0) == 0) begin
        key_en = ~key_en;
        key_in = codes[$urandom_range(4, 0)];
      end
      if (c == 10000) do_reset();
      else if (c % 700 == 350) begin
        int x, y;
        y = m_by - 5 + int'($urandom_range(59, 0));
        x = m_bx - 5 + int'($urandom_range(79, 0));
        if (y < 0) y = 0;
        if (y > 479) y = 479;
        if (x < 0) x = 0;
        if (x > 639) x = 639;
        set_addr(y * 640 + x);
      end else if (c % 1500 == 1000) set_addr(int'($urandom_range(FRAME_PIXELS - 1, 0)));
      tick();
    end

    run = 1'b0;
    #20;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
